dm_lsu: RTL and testbench

Parametrised data memory with a load/store unit for the pipelined CPU.
- Supports byte, halfword and word accesses, with sign or zero extension on loads and byte-lane merge on stores.
- Uses a valid/ready request port and an in-order response pipeline of configurable latency.
- Flags misaligned accesses instead of corrupting memory.
- Clears its storage sequentially after reset.
- Sits in the MEM stage, between the ALU result/rt forwarding and the W-stage writeback mux.

---
 rtl/dm_lsu.sv | 180 ++++++++++++++++++
 tb/tb_dm_lsu.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/dm_lsu.sv
`default_nettype none
// ============================================================================
// Module      : dm_lsu
// Description : Data memory with load/store unit for the MEM stage. Handles
//               byte/half/word accesses with sign or zero extension on loads,
//               byte-lane merge on stores and misalignment flagging. Responses
//               come back in order through a LATENCY-deep pipeline. Storage
//               is cleared word by word after reset.
//               Optional store trace: define DM_TRACE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module dm_lsu #(
    parameter int ADDR_WIDTH = 12,
    parameter int LATENCY    = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [1:0]  i_req_size,
    input  logic        i_req_signed,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    input  logic [31:0] i_req_pc,
    output logic        o_resp_valid,
    output logic [31:0] o_resp_rdata,
    output logic        o_resp_err,
    output logic        o_busy
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [0:0] {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    w_clr_we;
    logic [ADDR_WIDTH-1:0]   r_clr_cnt;

    logic [31:0]             r_mem [DEPTH];

    logic                    w_ready;
    logic                    w_accept;
    logic                    w_err;
    logic                    w_store_ok;
    logic [ADDR_WIDTH-1:0]   w_idx;
    logic [1:0]              w_lane;
    logic [31:0]             w_word;
    logic [31:0]             w_shift;
    logic [7:0]              w_byte;
    logic [15:0]             w_half;
    logic [31:0]             w_merged;
    logic [31:0]             w_load;
    logic [31:0]             w_resp_d;

    logic                    r_pv [LATENCY];
    logic [31:0]             r_pd [LATENCY];
    logic                    r_pe [LATENCY];

    // Upper address bits are ignored (wrap modulo DEPTH); PC only feeds the trace.
    logic                    w_unused_ok;
    assign w_unused_ok = ^{i_req_pc, i_req_addr[31:ADDR_WIDTH+2]};

    // Request decode. Reset blocks acceptance so a store on the reset edge is dropped.
    assign w_ready    = ~reset & (r_state == S_RUN);
    assign w_accept   = i_req_valid & w_ready;
    assign w_idx      = i_req_addr[ADDR_WIDTH+1:2];
    assign w_lane     = i_req_addr[1:0];
    assign w_err      = (i_req_size == 2'b11) ||
                        ((i_req_size == 2'b01) && w_lane[0]) ||
                        ((i_req_size == 2'b10) && (w_lane != 2'b00));
    assign w_store_ok = w_accept & i_req_we & ~w_err;

    // Asynchronous read: a store committed on an earlier edge is already visible.
    assign w_word  = r_mem[w_idx];
    assign w_shift = w_word >> {w_lane, 3'b000};
    assign w_byte  = w_shift[7:0];
    assign w_half  = w_lane[1] ? w_word[31:16] : w_word[15:0];

    // Store merge: replace only the addressed lanes of the current word.
    always_comb begin
        w_merged = w_word;
        case (i_req_size)
            2'b00:   w_merged[{w_lane, 3'b000} +: 8] = i_req_wdata[7:0];
            2'b01: begin
                if (w_lane[1]) w_merged[31:16] = i_req_wdata[15:0];
                else           w_merged[15:0]  = i_req_wdata[15:0];
            end
            2'b10:   w_merged = i_req_wdata;
            default: w_merged = w_word;
        endcase
    end

    // Load extraction and sign/zero extension.
    always_comb begin
        w_load = 32'h0;
        case (i_req_size)
            2'b00:   w_load = {{24{i_req_signed & w_byte[7]}}, w_byte};
            2'b01:   w_load = {{16{i_req_signed & w_half[15]}}, w_half};
            2'b10:   w_load = w_word;
            default: w_load = 32'h0;
        endcase
    end

    assign w_resp_d = (i_req_we | w_err) ? 32'h0 : w_load;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_CLEAR;
        else       r_state <= w_state_nxt;
    end

    // FSM next state: CLEAR walks every word once, then RUN forever.
    always_comb begin
        w_state_nxt = r_state;
        w_clr_we    = 1'b0;
        case (r_state)
            S_CLEAR: begin
                w_clr_we = 1'b1;
                if (r_clr_cnt == ADDR_WIDTH'(DEPTH - 1)) w_state_nxt = S_RUN;
            end
            S_RUN:   w_state_nxt = S_RUN;
            default: w_state_nxt = S_CLEAR;
        endcase
    end

    // Clear counter restarts at word 0 on every reset.
    always_ff @(posedge clk) begin
        if (reset)         r_clr_cnt <= '0;
        else if (w_clr_we) r_clr_cnt <= r_clr_cnt + 1'b1;
    end

    // Memory array: clear writes during CLEAR, merged store words during RUN.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (w_clr_we)        r_mem[r_clr_cnt] <= 32'h0;
            else if (w_store_ok) r_mem[w_idx]     <= w_merged;
        end
    end

`ifdef DM_TRACE_EN
    // Store trace at the acceptance edge.
    always_ff @(posedge clk) begin
        if (w_store_ok)
            $display("%d@%h: *%h <= %h", $time, i_req_pc, {i_req_addr[31:2], 2'b00}, w_merged);
    end
`endif

    // Response pipeline: one entry per accepted request, bubbles otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LATENCY; i++) begin
                r_pv[i] <= 1'b0;
                r_pd[i] <= 32'h0;
                r_pe[i] <= 1'b0;
            end
        end else begin
            r_pv[0] <= w_accept;
            r_pd[0] <= w_accept ? w_resp_d : 32'h0;
            r_pe[0] <= w_accept & w_err;
            for (int i = 1; i < LATENCY; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pd[i] <= r_pd[i-1];
                r_pe[i] <= r_pe[i-1];
            end
        end
    end

    assign o_req_ready  = w_ready;
    assign o_busy       = reset | (r_state == S_CLEAR);
    assign o_resp_valid = ~reset & r_pv[LATENCY-1];
    assign o_resp_rdata = reset ? 32'h0 : r_pd[LATENCY-1];
    assign o_resp_err   = ~reset & r_pe[LATENCY-1];

endmodule
`default_nettype wire

// File: tb/tb_dm_lsu.sv
`default_nettype none
// ============================================================================
// Module      : tb_dm_lsu
// Description : Scoreboard bench for dm_lsu (ADDR_WIDTH=4, LATENCY=3).
//               Stimulus pushes expected responses with their due edge; a
//               negedge monitor pops and compares data, error and timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dm_lsu;

    localparam int AW  = 4;
    localparam int LAT = 3;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        valid = 1'b0;
    logic        we    = 1'b0;
    logic        sgn   = 1'b0;
    logic [1:0]  size  = 2'b00;
    logic [31:0] addr  = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] pc    = 32'h0;
    logic        ready;
    logic        rv;
    logic        rerr;
    logic        busy;
    logic [31:0] rdata;

    dm_lsu #(.ADDR_WIDTH(AW), .LATENCY(LAT)) u_dut (
        .clk          (clk),
        .reset        (reset),
        .i_req_valid  (valid),
        .o_req_ready  (ready),
        .i_req_we     (we),
        .i_req_size   (size),
        .i_req_signed (sgn),
        .i_req_addr   (addr),
        .i_req_wdata  (wdata),
        .i_req_pc     (pc),
        .o_resp_valid (rv),
        .o_resp_rdata (rdata),
        .o_resp_err   (rerr),
        .o_busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic        e;
        int          due;
        string       nm;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   checks = 0;
    int   passes = 0;
    int   ecnt   = 0;
    int   nclr;

    always @(posedge clk) ecnt++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act === expv) passes++;
        else $display("FAIL %s: got %h expected %h", nm, act, expv);
    endtask

    // Monitor: compare every presented response against the scoreboard head.
    always @(negedge clk) begin
        if (rv === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_resp: got valid=1 expected valid=0 at edge %0d", ecnt);
            end else begin
                mon_e = q.pop_front();
                chk({mon_e.nm, "_rdata"}, rdata, mon_e.d);
                chk({mon_e.nm, "_err"}, {31'b0, rerr}, {31'b0, mon_e.e});
                chk({mon_e.nm, "_edge"}, ecnt, mon_e.due);
            end
        end else if (q.size() != 0 && ecnt >= q[0].due) begin
            mon_e = q.pop_front();
            checks++;
            $display("FAIL %s_missing: got no response expected one at edge %0d", mon_e.nm, mon_e.due);
        end
    end

    // Present one request for one cycle; called just after a rising edge.
    task automatic issue(input string nm, input logic w, input logic [1:0] s, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] ed, input logic ee);
        exp_t e;
        valid = 1'b1; we = w; size = s; sgn = sg; addr = a; wdata = wd; pc = pc + 4;
        e.d = ed; e.e = ee; e.due = ecnt + LAT; e.nm = nm;
        q.push_back(e);
        @(posedge clk); #1;
        valid = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while (q.size() != 0 && k < 50) begin
            @(posedge clk);
            k++;
        end
        @(posedge clk); #1;
    endtask

    // Reset for one edge, check outputs, then measure the clear sequence.
    task automatic reset_seq();
        reset = 1'b1;
        valid = 1'b0;
        q.delete();
        @(negedge clk);
        chk("rst_ready", {31'b0, ready}, 32'h0);
        chk("rst_valid", {31'b0, rv}, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_err", {31'b0, rerr}, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h1);
        @(posedge clk); #1;
        reset = 1'b0;
        nclr = 0;
        @(negedge clk);
        chk("clear_ready_low", {31'b0, ready}, 32'h0);
        while (busy && nclr < 200) begin
            nclr++;
            @(negedge clk);
        end
        chk("clear_len", nclr, 16);
        chk("ready_after_clear", {31'b0, ready}, 32'h1);
        @(posedge clk); #1;
    endtask

    initial begin
        @(posedge clk); #1;
        reset_seq();

        // Cleared memory.
        issue("ld0",      1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        // Word store, byte merge, extensions.
        issue("sw8",      1'b1, 2'b10, 1'b0, 32'h8, 32'h12345678, 32'h0, 1'b0);
        issue("sbA",      1'b1, 2'b00, 1'b0, 32'hA, 32'h000000AB, 32'h0, 1'b0);
        issue("lw8",      1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 32'h12AB5678, 1'b0);
        issue("lbA_s",    1'b0, 2'b00, 1'b1, 32'hA, 32'h0, 32'hFFFFFFAB, 1'b0);
        issue("lbA_u",    1'b0, 2'b00, 1'b0, 32'hA, 32'h0, 32'h000000AB, 1'b0);
        issue("lb8_s",    1'b0, 2'b00, 1'b1, 32'h8, 32'h0, 32'h00000078, 1'b0);
        issue("lw_wrap",  1'b0, 2'b10, 1'b0, 32'h48, 32'h0, 32'h12AB5678, 1'b0);
        // Halfword store at upper lane.
        issue("sh6",      1'b1, 2'b01, 1'b0, 32'h6, 32'hFFFF8001, 32'h0, 1'b0);
        issue("lh6_s",    1'b0, 2'b01, 1'b1, 32'h6, 32'h0, 32'hFFFF8001, 1'b0);
        issue("lh6_u",    1'b0, 2'b01, 1'b0, 32'h6, 32'h0, 32'h00008001, 1'b0);
        issue("lw4",      1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 32'h80010000, 1'b0);
        // Misaligned and reserved-size accesses.
        issue("sw5_err",  1'b1, 2'b10, 1'b0, 32'h5, 32'hDEADBEEF, 32'h0, 1'b1);
        issue("lh3_err",  1'b0, 2'b01, 1'b1, 32'h3, 32'h0, 32'h0, 1'b1);
        issue("sz3_err",  1'b0, 2'b11, 1'b0, 32'h8, 32'h0, 32'h0, 1'b1);
        issue("lw4_keep", 1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 32'h80010000, 1'b0);
        drain();

        // Four back-to-back loads; edges checked against LAT by the monitor.
        issue("b2b0",     1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 32'h12AB5678, 1'b0);
        issue("b2b1",     1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 32'h80010000, 1'b0);
        issue("b2b2",     1'b0, 2'b00, 1'b0, 32'h9, 32'h0, 32'h00000056, 1'b0);
        issue("b2b3",     1'b0, 2'b01, 1'b1, 32'hA, 32'h0, 32'h000012AB, 1'b0);
        drain();

        // Reset with two responses in flight; clear must wipe stored data.
        issue("swC",      1'b1, 2'b10, 1'b0, 32'hC, 32'hCAFEF00D, 32'h0, 1'b0);
        drain();
        issue("fly0",     1'b0, 2'b10, 1'b0, 32'hC, 32'h0, 32'hCAFEF00D, 1'b0);
        issue("fly1",     1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 32'h12AB5678, 1'b0);
        reset_seq();
        issue("lwC_clr",  1'b0, 2'b10, 1'b0, 32'hC, 32'h0, 32'h0, 1'b0);
        issue("lw8_clr",  1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 32'h0, 1'b0);
        issue("lw4_clr",  1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 32'h0, 1'b0);
        drain();

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
